// File: rtl/word_scroll_ctrl.sv
// Rotation controller for the four-digit "dE10" display.
// Advances a 2-bit index on a prescaled tick or on Step presses.
module word_scroll_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       En,
  input  logic       Dir,
  input  logic       Step,
  output logic [1:0] Rot,
  output logic       Tick,
  output logic [1:0] C3,
  output logic [1:0] C2,
  output logic [1:0] C1,
  output logic [1:0] C0
);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          en_s1, en_s2;
  logic          dir_s1, dir_s2;
  logic          step_s1, step_s2;
  logic          step_prev;
  logic          step_edge;
  logic [1:0]    rot_nxt;

  assign step_edge = step_s2 & ~step_prev;
  assign rot_nxt   = dir_s2 ? Rot - 2'd1 : Rot + 2'd1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      en_s1     <= 1'b0;
      en_s2     <= 1'b0;
      dir_s1    <= 1'b0;
      dir_s2    <= 1'b0;
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      en_s1     <= En;
      en_s2     <= en_s1;
      dir_s1    <= Dir;
      dir_s2    <= dir_s1;
      step_s1   <= Step;
      step_s2   <= step_s1;
      step_prev <= step_s2;
    end
  end

  // Pause requests and run requests take priority over advances.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= PAUSE;
      count <= '0;
      Rot   <= 2'd0;
      Tick  <= 1'b0;
    end else begin
      Tick <= 1'b0;
      unique case (state)
        RUN: begin
          if (!en_s2) begin
            state <= PAUSE;
            count <= '0;
          end else if (count == TERM) begin
            count <= '0;
            Rot   <= rot_nxt;
            Tick  <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        PAUSE: begin
          count <= '0;
          if (en_s2) begin
            state <= RUN;
          end else if (step_edge) begin
            Rot  <= rot_nxt;
            Tick <= 1'b1;
          end
        end
        default: begin
          state <= PAUSE;
          count <= '0;
        end
      endcase
    end
  end

  assign C3 = Rot;
  assign C2 = Rot + 2'd1;
  assign C1 = Rot + 2'd2;
  assign C0 = Rot + 2'd3;

endmodule

// File: tb/tb_word_scroll_ctrl.sv
// Bench for word_scroll_ctrl: directed scenarios plus random inputs
// checked against a delay-history behavioural model.
module tb_word_scroll_ctrl;

  localparam int TD = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic       Dir = 1'b0;
  logic       Step = 1'b0;
  logic [1:0] Rot;
  logic       Tick;
  logic [1:0] C3, C2, C1, C0;

  bit clk_run = 1'b0;
  int checks = 0;
  int errors = 0;

  // model state
  int m_rot = 0;
  bit m_tick = 0;
  bit m_run = 0;
  int m_el = 0;
  bit h_en[3];
  bit h_dir[3];
  bit h_step[3];

  word_scroll_ctrl #(.TICK_DIV(TD), .CW(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .En(En),
    .Dir(Dir),
    .Step(Step),
    .Rot(Rot),
    .Tick(Tick),
    .C3(C3),
    .C2(C2),
    .C1(C1),
    .C0(C0)
  );

  always #5 if (clk_run) Clock = ~Clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rot = 0;
    m_tick = 0;
    m_run = 0;
    m_el = 0;
    for (int i = 0; i < 3; i++) begin
      h_en[i] = 0;
      h_dir[i] = 0;
      h_step[i] = 0;
    end
  endtask

  function automatic int adv(input int r, input bit d);
    return d ? (r + 3) % 4 : (r + 1) % 4;
  endfunction

  // Inputs take two edges to become visible; a press is a 0->1 seen there.
  task automatic model_edge();
    bit en_v, dir_v, press;
    en_v = h_en[1];
    dir_v = h_dir[1];
    press = h_step[1] && !h_step[2];
    m_tick = 0;
    if (m_run) begin
      if (!en_v) begin
        m_run = 0;
      end else begin
        m_el++;
        if (m_el == TD) begin
          m_el = 0;
          m_rot = adv(m_rot, dir_v);
          m_tick = 1;
        end
      end
    end else if (en_v) begin
      m_run = 1;
      m_el = 0;
    end else if (press) begin
      m_rot = adv(m_rot, dir_v);
      m_tick = 1;
    end
    h_en[2] = h_en[1]; h_en[1] = h_en[0]; h_en[0] = En;
    h_dir[2] = h_dir[1]; h_dir[1] = h_dir[0]; h_dir[0] = Dir;
    h_step[2] = h_step[1]; h_step[1] = h_step[0]; h_step[0] = Step;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".rot"}, int'(Rot), m_rot);
    chk({tag, ".tick"}, int'(Tick), int'(m_tick));
    chk({tag, ".c3"}, int'(C3), m_rot);
    chk({tag, ".c2"}, int'(C2), (m_rot + 1) % 4);
    chk({tag, ".c1"}, int'(C1), (m_rot + 2) % 4);
    chk({tag, ".c0"}, int'(C0), (m_rot + 3) % 4);
  endtask

  task automatic cyc(input bit e, input bit d, input bit s,
                     input string tag);
    En = e;
    Dir = d;
    Step = s;
    @(posedge Clock);
    if (Reset) model_reset();
    else model_edge();
    #1;
    chk_outs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk_outs(tag);
  endtask

  initial begin
    // reset with the clock stopped
    Reset = 1'b1;
    #3;
    model_reset();
    chk_outs("rst_noclk");
    chk("rst_c_pattern", int'({C3, C2, C1, C0}), 8'b00_01_10_11);
    #10;
    Reset = 1'b0;
    #2;
    clk_run = 1'b1;

    // auto run forward, first advance TD edges after RUN entry (edge 3)
    for (int i = 1; i <= 13; i++) begin
      cyc(1, 0, 0, "run_fwd");
      if (i == 6) chk("first_adv_before", int'(Rot), 0);
      if (i == 7) chk("first_adv", int'(Rot), 1);
      if (i == 7) chk("first_tick", int'(Tick), 1);
      if (i == 8) chk("tick_one_cycle", int'(Tick), 0);
      if (i == 11) chk("second_adv", int'(Rot), 2);
    end

    // mid-run reset at Rot=2, count=2
    async_reset("midrun_rst");
    chk("midrun_rot0", int'(Rot), 0);
    #3;
    Reset = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, 0, 0, "rerun");
      if (i == 6) chk("rerun_no_early", int'(Rot), 0);
      if (i == 7) chk("rerun_first_adv", int'(Rot), 1);
    end

    // reverse
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, "run_rev");

    // pause and single steps
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, "pause");
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 5; i++) cyc(0, p[0], 1, "step_hi");
      for (int i = 0; i < 4; i++) cyc(0, p[0], 0, "step_lo");
    end

    // step held across reset release yields one step
    Step = 1'b1;
    async_reset("hold_rst");
    #4;
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, "hold_step");
      if (i == 2) chk("hold_before", int'(Rot), 0);
      if (i == 3) chk("hold_once", int'(Rot), 1);
      if (i == 8) chk("hold_no_repeat", int'(Rot), 1);
    end

    // pause priority: En_s2 falls on the terminal-count edge
    async_reset("prio_rst");
    #3;
    Reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(i <= 4, 0, i[1], "prio");
      if (i == 7) chk("prio_no_adv", int'(Rot), 0);
      if (i == 7) chk("prio_no_tick", int'(Tick), 0);
    end
    chk("prio_count0", int'(dut.count), 0);

    // random inputs against the model
    for (int i = 0; i < 600; i++) begin
      bit e, d, s;
      e = ($urandom_range(0, 15) == 0) ? !En : En;
      d = ($urandom_range(0, 7) == 0) ? !Dir : Dir;
      s = ($urandom_range(0, 3) == 0) ? !Step : Step;
      cyc(e, d, s, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_scroll_ctrl.md
# word_scroll_ctrl

Sequential rotation controller that drives the four-digit "dE10" character display automatically instead of from slide switches. It sits directly upstream of the 2-bit character multiplexer and the 7-segment character decoders. It produces a 2-bit rotation index and the four per-digit character codes derived from it. The index advances once per prescaled tick while running, or once per Step press while paused, in a selectable direction.

## Interface
- TICK_DIV, default 50000000: clock cycles per automatic advance (1 Hz at 50 MHz); legal range 2..2^CW
- CW, default 26: prescaler counter width
- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- En  in  1  asynchronous level input: 1 = run, 0 = pause
- Dir  in  1  asynchronous level input: 0 = advance (+1), 1 = retreat (-1)
- Step  in  1  asynchronous active-high pushbutton; rising edge = single step while paused
- Rot  out  2  current rotation index
- Tick  out  1  one-cycle pulse in the cycle after each Rot change
- C3, C2, C1, C0  out  2 each  digit codes for HEX3..HEX0

## Operation
- Input synchronisers:
  - En, Dir and Step each pass through a 2-flop synchroniser (s1, s2), reset to 0.
  - A Step edge is s2_step & ~prev_step; prev_step is reset to 0.
  - A Step held high through reset release therefore yields exactly one step, once it reaches s2.
- State machine, two states, reset state PAUSE:
  - PAUSE -> RUN when En_s2 = 1.
  - RUN -> PAUSE when En_s2 = 0.
  - The prescaler count is cleared to 0 on every transition.
- In RUN:
  - The count increments each cycle.
  - When count = TICK_DIV-1, the count wraps to 0, Rot advances and Tick pulses.
  - Step edges are ignored.
- In PAUSE:
  - The count is held at 0.
  - Each Step edge advances Rot by one and pulses Tick.
- Advance rule, all mod 4:
  - Dir_s2 = 0: Rot <= Rot+1; 3 wraps to 0.
  - Dir_s2 = 1: Rot <= Rot-1; 0 wraps to 3.
  - Dir_s2 is sampled at the moment of advance.
- Digit codes, combinational from registered Rot, mod 4: C3 = Rot, C2 = Rot+1, C1 = Rot+2, C0 = Rot+3.
  - Downstream decoder mapping: 0 = d, 1 = E, 2 = 1, 3 = 0.
  - Rot = 0 displays "dE10"; Rot = 1 displays "E10d".
- Simultaneous events:
  - If RUN is at terminal count while En_s2 = 0, the state goes to PAUSE and Rot does not advance.
  - If PAUSE sees a Step edge while En_s2 = 1, the state goes to RUN and the step is discarded.
- Reset mid-operation: Rot, Tick, count, state and all synchroniser/edge flops clear immediately and asynchronously, independent of Clock.
- Reset values: Rot = 0, Tick = 0, C3..C0 = 0,1,2,3.

## Timing
- Rot and Tick are registered; C3..C0 follow Rot in the same cycle.
- Input latency: an input change captured at edge k appears in s2 at edge k+1. Its effect on state, Rot or Tick registers at edge k+2.
- Step press to Rot change: 3 edges, counting the capturing edge as edge 1. Tick is high for exactly the one cycle after the Rot update.
- RUN period:
  - The first advance occurs TICK_DIV cycles after the edge that enters RUN.
  - Later advances are exactly TICK_DIV cycles apart.
- Tick is never high for two consecutive cycles; this holds because TICK_DIV >= 2 and the Step edge detector fires once per press.
- No handshake with downstream: consumers sample Rot/C* continuously; Tick is advisory.

## Test plan
- Reset: Reset=1 with Clock stopped -> Rot=0, Tick=0, C3..C0 = 0,1,2,3 immediately.
- Auto run (TICK_DIV=4): En=1, Dir=0 held after reset.
  - Rot sequence 0,1,2,3,0 with advances every 4 cycles.
  - The first advance is 4 cycles after RUN entry.
  - Tick pulses once per advance.
- Reverse (TICK_DIV=4): Dir=1 in RUN from Rot=0 -> Rot 3,2,1,0; C3..C0 = 3,0,1,2 when Rot=3.
- Single step: En=0, one Step pulse of 5 cycles -> Rot 0->1 exactly once, 3 edges after the press; Tick is one cycle wide. Step held high across reset release -> exactly one step.
- Pause priority (TICK_DIV=4): drop En so that En_s2=0 coincides with terminal count -> no advance, state PAUSE, count=0. Step edges while in RUN -> no change.
- Mid-run reset: assert Reset at Rot=2 with count=2 -> Rot=0 at once. After release with En=1, the first advance is a full TICK_DIV cycles after re-entering RUN.
